cpu_sram_like_bridge: RTL and testbench

CPU_SRAM_LIKE_BRIDGE -- requirements
Module: cpu_sram_like_bridge

---
 rtl/cpu_bus_pkg.sv | 18 +
 rtl/cpu_sram_like_bridge_if.sv | 27 ++
 rtl/bus_size_dec.sv | 22 ++
 rtl/cpu_sram_like_bridge.sv | 82 ++++++++
 tb/tb_cpu_sram_like_bridge.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared encodings for the CPU-side sram-like bus bridges: FSM states and
// transfer size codes.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } bridge_state_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

endpackage

// File: rtl/cpu_sram_like_bridge_if.sv
// Sram-like request/response bus between a CPU-side bridge (master) and
// the memory-side slave.
interface cpu_sram_like_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/bus_size_dec.sv
// Byte-enable to transfer-size decode: a single enable is a byte, an aligned
// adjacent pair is a half-word, everything else (including reads) is a word.
module bus_size_dec
  import cpu_bus_pkg::*;
#(
  parameter int WEN_W = 4
) (
  input  logic [WEN_W-1:0] wen,
  output size_e            size
);

  always_comb begin
    size = SIZE_WORD;
    for (int i = 0; i < WEN_W; i++) begin
      if (wen == (WEN_W'(1) << i)) size = SIZE_BYTE;
    end
    for (int i = 0; i + 1 < WEN_W; i += 2) begin
      if (wen == (WEN_W'(2'b11) << i)) size = SIZE_HALF;
    end
  end

endmodule

// File: rtl/cpu_sram_like_bridge.sv
// Converts a stall-style CPU memory port into sram-like req/addr_ok/data_ok
// transactions, one outstanding access at a time.
module cpu_sram_like_bridge
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WEN_W    = DATA_W / 8,
  parameter bit WRITE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic [WEN_W-1:0]  cpu_wen,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_longest_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  cpu_sram_like_bridge_if.master bus
);

  bridge_state_e     state, state_nxt;
  logic [DATA_W-1:0] rdata_hold;
  logic [WEN_W-1:0]  wen_eff;
  size_e             size_code;
  logic              req_c;

  // An instruction port never writes, so its enables read as zero.
  assign wen_eff = WRITE_EN ? cpu_wen : '0;

  bus_size_dec #(.WEN_W(WEN_W)) u_size_dec (
    .wen  (wen_eff),
    .size (size_code)
  );

  always_comb begin
    state_nxt = state;
    req_c     = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_en) begin
          req_c     = 1'b1;
          state_nxt = bus.addr_ok ? WAIT : REQ;
        end
      end
      REQ: begin
        req_c = 1'b1;
        if (bus.addr_ok) state_nxt = WAIT;
      end
      // data_ok is only meaningful here; elsewhere it is stale or early.
      WAIT: begin
        if (bus.data_ok) state_nxt = DONE;
      end
      DONE: begin
        if (!cpu_longest_stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rdata_hold <= '0;
    end else begin
      state <= state_nxt;
      if (state == WAIT && bus.data_ok) rdata_hold <= bus.rdata;
    end
  end

  // The CPU holds its inputs while stalled, so they feed the bus directly.
  assign bus.req   = req_c;
  assign bus.wr    = |wen_eff;
  assign bus.size  = size_code;
  assign bus.addr  = cpu_addr;
  assign bus.wdata = cpu_wdata;

  assign cpu_stall = cpu_en && (state != DONE);
  assign cpu_rdata = rdata_hold;

endmodule

// File: tb/tb_cpu_sram_like_bridge.sv
// Directed bench for cpu_sram_like_bridge: a per-cycle vector table plus
// hand-written addr_ok back-pressure and mid-transaction reset sequences.
module tb_cpu_sram_like_bridge;
  import cpu_bus_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WEN_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_en;
  logic [WEN_W-1:0]  cpu_wen;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_longest_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_sram_like_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  cpu_sram_like_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WEN_W(WEN_W), .WRITE_EN(1'b1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_en            (cpu_en),
    .cpu_wen           (cpu_wen),
    .cpu_addr          (cpu_addr),
    .cpu_wdata         (cpu_wdata),
    .cpu_longest_stall (cpu_longest_stall),
    .cpu_rdata         (cpu_rdata),
    .cpu_stall         (cpu_stall),
    .bus               (bus.master)
  );

  typedef struct {
    logic        rst, en;
    logic [3:0]  wen;
    logic        ao, dok, ls;
    logic [31:0] addr, rd;
    logic        e_req, e_stall, e_wr;
    logic [1:0]  e_size;
    logic [31:0] e_crd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mkv(logic r, logic en, logic [3:0] wen, logic ao,
                               logic dok, logic ls, logic [31:0] addr,
                               logic [31:0] rd, logic e_req, logic e_stall,
                               logic e_wr, logic [1:0] e_size,
                               logic [31:0] e_crd);
    vec_t v;
    v.rst = r; v.en = en; v.wen = wen; v.ao = ao; v.dok = dok; v.ls = ls;
    v.addr = addr; v.rd = rd; v.e_req = e_req; v.e_stall = e_stall;
    v.e_wr = e_wr; v.e_size = e_size; v.e_crd = e_crd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic en, input logic [3:0] wen,
                       input logic ao, input logic dok, input logic ls,
                       input logic [31:0] addr, input logic [31:0] rd);
    rst               = r;
    cpu_en            = en;
    cpu_wen           = wen;
    cpu_addr          = addr;
    cpu_wdata         = addr ^ 32'hFFFF_0000;
    cpu_longest_stall = ls;
    bus.addr_ok       = ao;
    bus.data_ok       = dok;
    bus.rdata         = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive('1, '0, 4'h0, '0, '0, '0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    tbl.push_back(mkv('1,'0,4'h0,'0,'0,'0,32'h0,        32'h0,        '0,'0,'0,2'd2,32'h0));
    // Read: addr_ok at once, data_ok three cycles later
    tbl.push_back(mkv('0,'1,4'h0,'1,'0,'0,32'h1000_0000,32'h0,        '1,'1,'0,2'd2,32'h0));
    tbl.push_back(mkv('0,'1,4'h0,'0,'0,'0,32'h1000_0000,32'h0,        '0,'1,'0,2'd2,32'h0));
    tbl.push_back(mkv('0,'1,4'h0,'0,'0,'0,32'h1000_0000,32'h0,        '0,'1,'0,2'd2,32'h0));
    tbl.push_back(mkv('0,'1,4'h0,'0,'1,'0,32'h1000_0000,32'h1234_5678,'0,'1,'0,2'd2,32'h0));
    tbl.push_back(mkv('0,'1,4'h0,'0,'0,'0,32'h1000_0000,32'h0,        '0,'0,'0,2'd2,32'h1234_5678));
    tbl.push_back(mkv('0,'0,4'h0,'0,'0,'0,32'h0,        32'h0,        '0,'0,'0,2'd2,32'h1234_5678));
    // Half-word write, one REQ cycle, then DONE held by longest_stall
    tbl.push_back(mkv('0,'1,4'h3,'0,'0,'0,32'h8000_0010,32'h0,        '1,'1,'1,2'd1,32'h1234_5678));
    tbl.push_back(mkv('0,'1,4'h3,'1,'0,'0,32'h8000_0010,32'h0,        '1,'1,'1,2'd1,32'h1234_5678));
    tbl.push_back(mkv('0,'1,4'h3,'0,'1,'0,32'h8000_0010,32'hAAAA_5555,'0,'1,'1,2'd1,32'h1234_5678));
    tbl.push_back(mkv('0,'1,4'h3,'0,'0,'1,32'h8000_0010,32'h1111_1111,'0,'0,'1,2'd1,32'hAAAA_5555));
    tbl.push_back(mkv('0,'1,4'h3,'0,'0,'1,32'h8000_0010,32'h2222_2222,'0,'0,'1,2'd1,32'hAAAA_5555));
    tbl.push_back(mkv('0,'1,4'h3,'0,'0,'1,32'h8000_0010,32'h3333_3333,'0,'0,'1,2'd1,32'hAAAA_5555));
    tbl.push_back(mkv('0,'1,4'h3,'0,'0,'0,32'h8000_0010,32'h0,        '0,'0,'1,2'd1,32'hAAAA_5555));
    // data_ok together with addr_ok counts only as acceptance
    tbl.push_back(mkv('0,'1,4'h1,'1,'1,'0,32'h8000_0020,32'hDEAD_BEEF,'1,'1,'1,2'd0,32'hAAAA_5555));
    tbl.push_back(mkv('0,'1,4'h1,'0,'0,'0,32'h8000_0020,32'h0,        '0,'1,'1,2'd0,32'hAAAA_5555));
    tbl.push_back(mkv('0,'1,4'h1,'0,'1,'0,32'h8000_0020,32'h0000_BEEF,'0,'1,'1,2'd0,32'hAAAA_5555));
    // Back-to-back: new request in the cycle right after DONE
    tbl.push_back(mkv('0,'1,4'h0,'0,'0,'0,32'h8000_0030,32'h0,        '0,'0,'0,2'd2,32'h0000_BEEF));
    tbl.push_back(mkv('0,'1,4'h0,'1,'0,'0,32'h8000_0030,32'h0,        '1,'1,'0,2'd2,32'h0000_BEEF));
    tbl.push_back(mkv('0,'1,4'h0,'0,'1,'0,32'h8000_0030,32'hCAFE_F00D,'0,'1,'0,2'd2,32'h0000_BEEF));
    tbl.push_back(mkv('0,'0,4'h0,'0,'0,'0,32'h0,        32'h0,        '0,'0,'0,2'd2,32'hCAFE_F00D));
    // Upper half write; stray data_ok in REQ is ignored
    tbl.push_back(mkv('0,'1,4'hC,'0,'0,'0,32'h8000_0042,32'h0,        '1,'1,'1,2'd1,32'hCAFE_F00D));
    tbl.push_back(mkv('0,'1,4'hC,'0,'1,'0,32'h8000_0042,32'hFFFF_FFFF,'1,'1,'1,2'd1,32'hCAFE_F00D));
    tbl.push_back(mkv('0,'1,4'hC,'1,'0,'0,32'h8000_0042,32'h0,        '1,'1,'1,2'd1,32'hCAFE_F00D));
    tbl.push_back(mkv('0,'1,4'hC,'0,'1,'0,32'h8000_0042,32'h0102_0304,'0,'1,'1,2'd1,32'hCAFE_F00D));
    tbl.push_back(mkv('0,'0,4'h0,'0,'0,'0,32'h0,        32'h0,        '0,'0,'0,2'd2,32'h0102_0304));
    // Size decode of odd enable patterns while parked in REQ
    tbl.push_back(mkv('0,'1,4'h6,'0,'0,'0,32'h8000_0050,32'h0,        '1,'1,'1,2'd2,32'h0102_0304));
    tbl.push_back(mkv('0,'1,4'h8,'0,'0,'0,32'h8000_0050,32'h0,        '1,'1,'1,2'd0,32'h0102_0304));
    tbl.push_back(mkv('0,'1,4'hF,'0,'0,'0,32'h8000_0050,32'h0,        '1,'1,'1,2'd2,32'h0102_0304));
    tbl.push_back(mkv('0,'1,4'h4,'0,'0,'0,32'h8000_0050,32'h0,        '1,'1,'1,2'd0,32'h0102_0304));
    tbl.push_back(mkv('0,'1,4'h7,'0,'0,'0,32'h8000_0050,32'h0,        '1,'1,'1,2'd2,32'h0102_0304));
    // Reset from REQ clears the hold register; later data_ok is stale
    tbl.push_back(mkv('1,'0,4'h0,'0,'0,'0,32'h0,        32'h0,        '1,'0,'0,2'd2,32'h0102_0304));
    tbl.push_back(mkv('0,'0,4'h0,'0,'1,'0,32'h0,        32'h9999_9999,'0,'0,'0,2'd2,32'h0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].wen, tbl[i].ao, tbl[i].dok,
            tbl[i].ls, tbl[i].addr, tbl[i].rd);
      @(negedge clk);
      chk($sformatf("v%0d req", i), 32'(bus.req), 32'(tbl[i].e_req));
      chk($sformatf("v%0d cpu_stall", i), 32'(cpu_stall), 32'(tbl[i].e_stall));
      chk($sformatf("v%0d cpu_rdata", i), cpu_rdata, tbl[i].e_crd);
      if (tbl[i].e_req) begin
        chk($sformatf("v%0d wr", i), 32'(bus.wr), 32'(tbl[i].e_wr));
        chk($sformatf("v%0d size", i), 32'(bus.size), 32'(tbl[i].e_size));
        chk($sformatf("v%0d addr", i), bus.addr, tbl[i].addr);
        chk($sformatf("v%0d wdata", i), bus.wdata, tbl[i].addr ^ 32'hFFFF_0000);
      end
      next_cycle();
    end

    // addr_ok withheld five cycles: request and address stay put
    for (int k = 0; k < 5; k++) begin
      drive('0, '1, 4'h0, '0, '0, '0, 32'h8000_0100, 32'h0);
      @(negedge clk);
      chk($sformatf("hold%0d req", k), 32'(bus.req), 32'd1);
      chk($sformatf("hold%0d stall", k), 32'(cpu_stall), 32'd1);
      chk($sformatf("hold%0d addr", k), bus.addr, 32'h8000_0100);
      next_cycle();
    end
    drive('0, '1, 4'h0, '1, '0, '0, 32'h8000_0100, 32'h0);
    @(negedge clk);
    chk("hold accept req", 32'(bus.req), 32'd1);
    next_cycle();
    drive('0, '1, 4'h0, '0, '1, '0, 32'h8000_0100, 32'h0BAD_F00D);
    @(negedge clk);
    chk("hold wait req", 32'(bus.req), 32'd0);
    chk("hold wait stall", 32'(cpu_stall), 32'd1);
    next_cycle();
    drive('0, '1, 4'h0, '0, '0, '0, 32'h8000_0100, 32'h0);
    @(negedge clk);
    chk("hold done stall", 32'(cpu_stall), 32'd0);
    chk("hold done rdata", cpu_rdata, 32'h0BAD_F00D);
    next_cycle();

    // Reset while in WAIT, then a stale data_ok
    drive('0, '1, 4'h0, '1, '0, '0, 32'h8000_0200, 32'h0);
    @(negedge clk);
    chk("rstw req", 32'(bus.req), 32'd1);
    next_cycle();
    drive('1, '1, 4'h0, '0, '0, '0, 32'h8000_0200, 32'h0);
    @(negedge clk);
    chk("rstw wait stall", 32'(cpu_stall), 32'd1);
    chk("rstw wait req", 32'(bus.req), 32'd0);
    next_cycle();
    drive('0, '0, 4'h0, '0, '1, '0, 32'h0, 32'h5555_5555);
    @(negedge clk);
    chk("rstw cleared rdata", cpu_rdata, 32'h0);
    chk("rstw idle stall", 32'(cpu_stall), 32'd0);
    chk("rstw idle req", 32'(bus.req), 32'd0);
    next_cycle();
    drive('0, '1, 4'h0, '0, '0, '0, 32'h8000_0300, 32'h0);
    @(negedge clk);
    chk("rstw no done rdata", cpu_rdata, 32'h0);
    chk("rstw no done stall", 32'(cpu_stall), 32'd1);
    chk("rstw new req", 32'(bus.req), 32'd1);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
